// File: rtl/run_sequencer.sv
// Initiator side of the go/done handshake: issues a batch of RUNS go pulses,
// waits for each done rise/fall, counts completed runs and flags stalls.
module run_sequencer #(
  parameter int RUNS           = 3,
  parameter int TIMEOUT_CYCLES = 60_000_000,
  parameter int GAP_CYCLES     = 1_200_000,
  parameter int TIMER_W        = 26
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       start,
  input  logic       done_sig,
  output logic       go,
  output logic       busy,
  output logic [3:0] led,
  output logic       error,
  output logic       batch_done
);

  // state     | meaning
  // S_IDLE    | waiting for start, led shows last batch count
  // S_ISSUE   | one-cycle go pulse to the responder
  // S_WAIT_HI | waiting for done_sig to rise (timed)
  // S_WAIT_LO | waiting for done_sig to fall (timed), counts the run
  // S_GAP     | fixed idle spacing before the next go
  // S_FINISH  | one-cycle batch_done pulse
  // S_ERROR   | responder stalled; sticky until the next start
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4,
    S_FINISH  = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [3:0]         RUNS_L   = 4'(RUNS);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           led_q,   led_d;
  logic [3:0]           led_inc;

  assign led_inc = led_q + 4'd1;

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    led_d   = led_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d = S_ISSUE;
          led_d   = '0;
          timer_d = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_HI;
        timer_d = '0;
      end
      S_WAIT_HI: begin
        if (done_sig) begin
          state_d = S_WAIT_LO;
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!done_sig) begin
          led_d   = led_inc;
          timer_d = '0;
          state_d = (led_inc == RUNS_L) ? S_FINISH : S_GAP;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_GAP: begin
        // timer counts 0..GAP_CYCLES-1 so the gap lasts exactly GAP_CYCLES cycles
        if (timer_q == GAP_LAST) begin
          state_d = S_ISSUE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    go         = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    batch_done = 1'b0;
    case (state_q)
      S_ISSUE:   begin go = 1'b1; busy = 1'b1; end
      S_WAIT_HI: busy = 1'b1;
      S_WAIT_LO: busy = 1'b1;
      S_GAP:     busy = 1'b1;
      S_FINISH:  batch_done = 1'b1;
      S_ERROR:   error = 1'b1;
      default:   ;
    endcase
  end

  assign led = led_q;

endmodule
